router_ingress_arb: RTL
=======================

ROUTER_INGRESS_ARB -- requirements
Module: router_ingress_arb

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have port src_valid, input, 3 bits: bit i set means source i presents a packet byte.
REQ-004 SHALL have ports src_data0, src_data1, src_data2, input, 8 bits each: the packet byte from each source.
REQ-005 SHALL have port src_ready, output, 3 bits: the byte from source i is accepted when src_valid[i] and src_ready[i] are both high at a clock edge.
REQ-006 SHALL have port rtr_busy, input, 1 bit: the router's busy signal; while it is high the router is not sampling.
REQ-007 SHALL have port rtr_data, output, 8 bits: registered byte driven to the router data input.
REQ-008 SHALL have port rtr_pkt_valid, output, 1 bit: registered; high for the header byte and the payload bytes, low for the parity byte.
REQ-009 SHALL have port gnt, output, 3 bits: one-hot, identifies the granted source, all zero when no source is granted.
REQ-010 SHALL have port parity_err, output, 1 bit: one-cycle pulse.
REQ-011 SHALL have port drop, output, 1 bit: one-cycle pulse.
REQ-012 SHALL have port proto_err, output, 1 bit: sticky flag.

Function
REQ-013 Packet format SHALL be: header {len[7:2], addr[1:0]}, then len payload bytes, then 1 parity byte; the parity byte is the XOR of the header and all payload bytes.
REQ-014 States SHALL be IDLE, HDR, PAY, PAR, GAP.
REQ-015 In IDLE the block SHALL grant the first source with src_valid set, searched round-robin starting at last_gnt+1 (mod 3); gnt is registered and the state moves to HDR on the next edge.
REQ-016 In HDR, PAY and PAR, src_ready[g] SHALL equal ~rtr_busy; all other src_ready bits are 0.
REQ-017 Every accepted byte SHALL appear on rtr_data on the following edge (1-cycle latency); rtr_data and rtr_pkt_valid hold their values while rtr_busy is high.
REQ-018 When the header is accepted, the block SHALL latch len into a 6-bit down-counter, drive rtr_pkt_valid to 1, and go to PAY if len is nonzero, otherwise to PAR.
REQ-019 In PAY the block SHALL decrement the counter on each accepted byte; when the counter reaches 0 after an accept, the state goes to PAR.
REQ-020 On parity accept the block SHALL load rtr_data with the parity byte, set rtr_pkt_valid to 0, compare against the running XOR, pulse parity_err on mismatch (the byte is forwarded anyway), and go to GAP.
REQ-021 GAP SHALL last until the first cycle in which rtr_busy is low, then go to IDLE and update last_gnt; this guarantees at least 1 idle cycle between packets.
REQ-022 A header with addr equal to 2'b11 SHALL cause the block to pulse drop, keep rtr_pkt_valid at 0, hold src_ready[g] high regardless of rtr_busy, and consume len+1 further bytes without forwarding them.
REQ-023 src_valid[g] low while src_ready[g] is high in HDR, PAY or PAR SHALL set proto_err; the block holds its outputs and waits, and the counter does not advance.
REQ-024 Requests from ungranted sources arriving mid-packet SHALL be ignored until IDLE.
REQ-025 len equal to 63 (the maximum) SHALL be handled with no counter wrap.

Reset
REQ-026 While rst is high the block SHALL set state to IDLE, gnt to 0, src_ready to 0, rtr_data to 8'h00, rtr_pkt_valid to 0, parity_err to 0, drop to 0, proto_err to 0, and last_gnt to 2 (so source 0 wins first).
REQ-027 rst asserted mid-packet SHALL abort the packet immediately; there is no resume after reset.

Structure
REQ-028 Package router_pkg SHALL hold the state enum, ADDR_DROP = 2'b11, LEN_W = 6, and DATA_W = 8.
REQ-029 Round-robin selection SHALL be implemented in sub-module rr_arb3 (inputs: req[2:0] and last_gnt; output: one-hot grant); it is purely combinational.

Verification
REQ-030 Source 0 sends header 8'h38 (len 14, addr 0), 14 payload bytes and correct parity, with rtr_busy = 0 -> rtr_data shows 16 bytes on consecutive cycles starting 1 cycle after the header accept; rtr_pkt_valid is high for 15 cycles then low; parity_err stays 0.
REQ-031 All 3 sources request simultaneously after reset -> grant order is 0, 1, 2, 0; GAP lasts at least 1 cycle between packets.
REQ-032 rtr_busy is held high for 3 cycles mid-payload on a packet with header 8'h21 (len 8, addr 1) -> src_ready drops to 0, rtr_data is held for 3 cycles, and no byte is lost or duplicated.
REQ-033 Source 2 sends header 8'h43 (len 16, addr 3) -> drop pulses once, rtr_pkt_valid stays 0, 17 further bytes are consumed, and the block returns to IDLE.
REQ-034 A packet with a corrupted parity byte (expected ^ 8'h01) -> parity_err pulses exactly once, in the cycle the parity byte is accepted.
REQ-035 rst pulsed during byte 5 of a len 21 packet -> all outputs return to their reset values asynchronously; the next grant goes to source 0.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and constants for the router ingress arbiter.
package router_pkg;

    localparam int unsigned LEN_W  = 6;
    localparam int unsigned DATA_W = 8;
    localparam logic [1:0]  ADDR_DROP = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PAY,
        PAR,
        GAP
    } state_t;

    // One-hot 3-bit grant to source index (defaults to 0 for an empty vector).
    function automatic logic [1:0] oh_to_idx(input logic [2:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        if (oh[1]) idx = 2'd1;
        if (oh[2]) idx = 2'd2;
        return idx;
    endfunction

endpackage

// File: rtl/rr_arb3.sv
// Three-way round-robin selector: first requester after last_gnt wins.
module rr_arb3 (
    input  logic [2:0] req,
    input  logic [1:0] last_gnt,
    output logic [2:0] gnt
);

    logic [1:0] idx;

    // Walk the sources starting one past the previous winner, modulo 3.
    always_comb begin
        gnt = '0;
        idx = last_gnt;
        for (int unsigned k = 0; k < 3; k++) begin
            idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
            if (gnt == '0 && req[idx]) begin
                gnt[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/router_ingress_arb.sv
// Ingress arbiter: grants one of three byte-stream sources per packet and
// forwards header/payload/parity to the router with a one-cycle register stage.
module router_ingress_arb
    import router_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        src_valid,
    input  logic [DATA_W-1:0] src_data0,
    input  logic [DATA_W-1:0] src_data1,
    input  logic [DATA_W-1:0] src_data2,
    output logic [2:0]        src_ready,
    input  logic              rtr_busy,
    output logic [DATA_W-1:0] rtr_data,
    output logic              rtr_pkt_valid,
    output logic [2:0]        gnt,
    output logic              parity_err,
    output logic              drop,
    output logic              proto_err
);

    state_t            state_q;
    logic [2:0]        gnt_q;
    logic [1:0]        last_gnt_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [DATA_W-1:0] xor_q;
    logic              drop_mode_q;
    logic [DATA_W-1:0] rtr_data_q;
    logic              pkt_valid_q;
    logic              parity_err_q;
    logic              drop_q;
    logic              proto_err_q;

    logic [2:0]        arb_gnt;
    logic              in_pkt;
    logic              sel_valid;
    logic [DATA_W-1:0] sel_data;
    logic              accept;
    logic              stall;

    rr_arb3 u_rr (
        .req      (src_valid),
        .last_gnt (last_gnt_q),
        .gnt      (arb_gnt)
    );

    // Handshake decode for the granted source; a dropped packet ignores rtr_busy.
    always_comb begin
        in_pkt    = (state_q == HDR) || (state_q == PAY) || (state_q == PAR);
        src_ready = in_pkt ? (gnt_q & {3{~rtr_busy | drop_mode_q}}) : '0;
        sel_valid = |(src_valid & gnt_q);
        sel_data  = '0;
        if (gnt_q[0]) sel_data = src_data0;
        if (gnt_q[1]) sel_data = src_data1;
        if (gnt_q[2]) sel_data = src_data2;
        accept    = |(src_valid & src_ready);
        stall     = (|src_ready) && !sel_valid;
    end

    // Packet FSM with registered router-side outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            last_gnt_q   <= 2'd2;
            cnt_q        <= '0;
            xor_q        <= '0;
            drop_mode_q  <= 1'b0;
            rtr_data_q   <= '0;
            pkt_valid_q  <= 1'b0;
            parity_err_q <= 1'b0;
            drop_q       <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            parity_err_q <= 1'b0;
            drop_q       <= 1'b0;
            if (stall) begin
                proto_err_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (|src_valid) begin
                        gnt_q       <= arb_gnt;
                        drop_mode_q <= 1'b0;
                        state_q     <= HDR;
                    end
                end
                HDR: begin
                    if (accept) begin
                        cnt_q <= sel_data[DATA_W-1 -: LEN_W];
                        if (sel_data[1:0] == ADDR_DROP) begin
                            drop_q      <= 1'b1;
                            drop_mode_q <= 1'b1;
                        end else begin
                            rtr_data_q  <= sel_data;
                            pkt_valid_q <= 1'b1;
                            xor_q       <= sel_data;
                        end
                        state_q <= (sel_data[DATA_W-1 -: LEN_W] != '0) ? PAY : PAR;
                    end
                end
                PAY: begin
                    if (accept) begin
                        cnt_q <= cnt_q - LEN_W'(1);
                        if (!drop_mode_q) begin
                            rtr_data_q <= sel_data;
                            xor_q      <= xor_q ^ sel_data;
                        end
                        if (cnt_q == LEN_W'(1)) begin
                            state_q <= PAR;
                        end
                    end
                end
                PAR: begin
                    if (accept) begin
                        if (!drop_mode_q) begin
                            rtr_data_q   <= sel_data;
                            pkt_valid_q  <= 1'b0;
                            parity_err_q <= (sel_data != xor_q);
                        end
                        state_q <= GAP;
                    end
                end
                GAP: begin
                    if (!rtr_busy) begin
                        last_gnt_q  <= oh_to_idx(gnt_q);
                        gnt_q       <= '0;
                        drop_mode_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt           = gnt_q;
    assign rtr_data      = rtr_data_q;
    assign rtr_pkt_valid = pkt_valid_q;
    assign parity_err    = parity_err_q;
    assign drop          = drop_q;
    assign proto_err     = proto_err_q;

endmodule
